// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin against the last winner, or fixed priority to port 0.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_lp,
  input  logic       i_rr_en,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    // On a tie, round-robin favours the port that did not win last; otherwise port 0.
    if (&i_req) begin
      o_gnt = (i_rr_en && !i_lp) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between the core (port 0) and a debug/DMA loader (port 1).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter bit          RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  state_e        r_state;
  state_e        w_state_d;
  logic          r_lp;
  logic          r_cmd_we;
  logic [AW-1:0] r_cmd_a;
  logic [DW-1:0] r_cmd_wd;
  logic          r_cmd_id;
  logic          r_done0;
  logic          r_done1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic [1:0]    w_pick;
  logic [1:0]    w_gnt;
  logic          w_rr_en;

  assign w_rr_en = RR;

  rr_pick2 u_pick (
    .i_req   ({req1, req0}),
    .i_lp    (r_lp),
    .i_rr_en (w_rr_en),
    .o_gnt   (w_pick)
  );

  always_comb begin
    w_state_d = r_state;
    w_gnt     = 2'b00;
    unique case (r_state)
      IDLE: begin
        if (rst) begin
          w_gnt = w_pick;
          if (|w_pick) w_state_d = SERVE;
        end
      end
      SERVE: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lp     <= 1'b1;
      r_cmd_we <= 1'b0;
      r_cmd_a  <= '0;
      r_cmd_wd <= '0;
      r_cmd_id <= PORT_CORE;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (|w_gnt) begin
        r_cmd_we <= w_gnt[1] ? we1    : we0;
        r_cmd_a  <= w_gnt[1] ? addr1  : addr0;
        r_cmd_wd <= w_gnt[1] ? wdata1 : wdata0;
        r_cmd_id <= w_gnt[1];
        r_lp     <= w_gnt[1];
      end
      // Read data is captured for stores too; it is the pre-write content.
      if (r_state == SERVE) begin
        if (r_cmd_id == PORT_CORE) begin
          r_done0  <= 1'b1;
          r_rdata0 <= mem_rd;
        end else begin
          r_done1  <= 1'b1;
          r_rdata1 <= mem_rd;
        end
      end
    end
  end

  assign gnt0   = w_gnt[0];
  assign gnt1   = w_gnt[1];
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign mem_we = (r_state == SERVE) & r_cmd_we & rst;
  assign mem_a  = r_cmd_a;
  assign mem_wd = r_cmd_wd;
  assign busy   = (r_state == SERVE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } sb_entry_t;

  logic          clk;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          mem_init;

  logic          a_gnt0, a_gnt1, a_done0, a_done1, a_mem_we, a_busy;
  logic [DW-1:0] a_rdata0, a_rdata1, a_mem_wd, a_mem_rd;
  logic [AW-1:0] a_mem_a;
  logic          b_gnt0, b_gnt1, b_done0, b_done1, b_mem_we, b_busy;
  logic [DW-1:0] b_rdata0, b_rdata1, b_mem_wd, b_mem_rd;
  logic [AW-1:0] b_mem_a;

  logic [DW-1:0] mem_arr_a [256];
  logic [DW-1:0] mem_arr_b [256];
  logic [DW-1:0] ref_mem   [256];
  sb_entry_t     sb [$];

  int n_cmp;
  int n_err;

  dmem_arbiter #(.AW(AW), .DW(DW), .RR(1'b1)) u_dut_rr (
    .clk (clk), .rst (rst),
    .req0 (req0), .we0 (we0), .addr0 (addr0), .wdata0 (wdata0),
    .gnt0 (a_gnt0), .done0 (a_done0), .rdata0 (a_rdata0),
    .req1 (req1), .we1 (we1), .addr1 (addr1), .wdata1 (wdata1),
    .gnt1 (a_gnt1), .done1 (a_done1), .rdata1 (a_rdata1),
    .mem_we (a_mem_we), .mem_a (a_mem_a), .mem_wd (a_mem_wd), .mem_rd (a_mem_rd),
    .busy (a_busy)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .RR(1'b0)) u_dut_fp (
    .clk (clk), .rst (rst),
    .req0 (req0), .we0 (we0), .addr0 (addr0), .wdata0 (wdata0),
    .gnt0 (b_gnt0), .done0 (b_done0), .rdata0 (b_rdata0),
    .req1 (req1), .we1 (we1), .addr1 (addr1), .wdata1 (wdata1),
    .gnt1 (b_gnt1), .done1 (b_done1), .rdata1 (b_rdata1),
    .mem_we (b_mem_we), .mem_a (b_mem_a), .mem_wd (b_mem_wd), .mem_rd (b_mem_rd),
    .busy (b_busy)
  );

  assign a_mem_rd = mem_arr_a[a_mem_a];
  assign b_mem_rd = mem_arr_b[b_mem_a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_arr_a[i] <= DW'(i);
        mem_arr_b[i] <= DW'(i);
      end
    end else begin
      if (a_mem_we) mem_arr_a[a_mem_a] <= a_mem_wd;
      if (b_mem_we) mem_arr_b[b_mem_a] <= b_mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the round-robin instance: push on grant, pop on done.
  always @(negedge clk) begin
    sb_entry_t e;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i);
    end
    if (!rst) begin
      sb.delete();
    end else begin
      if (a_done0 || a_done1) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_port", {a_done1, a_done0}, e.port ? 2'b10 : 2'b01);
          chk("sb_rdata", e.port ? a_rdata1 : a_rdata0, ref_mem[e.addr]);
          if (e.we) ref_mem[e.addr] = e.wd;
        end
      end
      if (a_gnt0 || a_gnt1) begin
        chk("gnt_onehot", a_gnt0 & a_gnt1, 1'b0);
        e.port = a_gnt1;
        e.we   = a_gnt1 ? we1 : we0;
        e.addr = a_gnt1 ? addr1 : addr0;
        e.wd   = a_gnt1 ? wdata1 : wdata0;
        sb.push_back(e);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g, exp_d, exp_bg;
    n_cmp = 0;
    n_err = 0;
    mem_init = 1'b1;
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) next_cyc();
    mem_init = 1'b0;

    // Reset state, with requests present that must not be granted.
    req0 = 1'b1; req1 = 1'b1; #1;
    chk("rst_gnt_rr", {a_gnt1, a_gnt0}, 2'b00);
    chk("rst_gnt_fp", {b_gnt1, b_gnt0}, 2'b00);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", {a_done1, a_done0}, 2'b00);
    chk("rst_rdata0", a_rdata0, 32'h0);
    chk("rst_rdata1", a_rdata1, 32'h0);
    chk("rst_mem_we", a_mem_we, 1'b0);
    chk("rst_mem_a", a_mem_a, 8'h0);
    req0 = 1'b0; req1 = 1'b0;

    // Single load from port 0.
    next_cyc(); rst = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 8'd5; #1;
    chk("ld_gnt", {a_gnt1, a_gnt0}, 2'b01);
    next_cyc(); req0 = 1'b0; #1;
    chk("ld_busy", a_busy, 1'b1);
    chk("ld_mem_a", a_mem_a, 8'd5);
    chk("ld_mem_we", a_mem_we, 1'b0);
    chk("ld_early_done", {a_done1, a_done0}, 2'b00);
    next_cyc(); #1;
    chk("ld_done", {a_done1, a_done0}, 2'b01);
    chk("ld_rdata0", a_rdata0, 32'd5);
    chk("ld_rdata1", a_rdata1, 32'd0);
    chk("ld_busy_after", a_busy, 1'b0);

    // Store then load on port 1, the load requested in the store's done cycle.
    next_cyc(); req1 = 1'b1; we1 = 1'b1; addr1 = 8'd7; wdata1 = 32'hDEAD_BEEF; #1;
    chk("st_gnt", {a_gnt1, a_gnt0}, 2'b10);
    chk("st_we_idle", a_mem_we, 1'b0);
    next_cyc(); req1 = 1'b0; #1;
    chk("st_mem_we", a_mem_we, 1'b1);
    chk("st_mem_a", a_mem_a, 8'd7);
    chk("st_mem_wd", a_mem_wd, 32'hDEAD_BEEF);
    next_cyc(); req1 = 1'b1; we1 = 1'b0; #1;
    chk("st_done", {a_done1, a_done0}, 2'b10);
    chk("st_rdata1_old", a_rdata1, 32'd7);
    chk("st_we_after", a_mem_we, 1'b0);
    chk("ld7_gnt", {a_gnt1, a_gnt0}, 2'b10);
    next_cyc(); req1 = 1'b0; #1;
    chk("ld7_done_once", {a_done1, a_done0}, 2'b00);
    chk("ld7_mem_we", a_mem_we, 1'b0);
    next_cyc(); #1;
    chk("ld7_done", {a_done1, a_done0}, 2'b10);
    chk("ld7_rdata1", a_rdata1, 32'hDEAD_BEEF);
    next_cyc(); #1;
    chk("ld7_done_clr", {a_done1, a_done0}, 2'b00);

    // Contention from reset: both ports request continuously.
    rst = 1'b0;
    next_cyc();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'd1; addr1 = 8'd2;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) next_cyc();
      if (k == 8) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      #1;
      exp_g  = 2'b00;
      exp_bg = 2'b00;
      exp_d  = 2'b00;
      if (k < 8 && k % 4 == 0) exp_g = 2'b01;
      if (k < 8 && k % 4 == 2) exp_g = 2'b10;
      if (k < 8 && k % 2 == 0) exp_bg = 2'b01;
      if (k >= 2 && k % 2 == 0) exp_d = ((k - 2) % 4 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr_gnt_c%0d", k), {a_gnt1, a_gnt0}, exp_g);
      chk($sformatf("rr_done_c%0d", k), {a_done1, a_done0}, exp_d);
      chk($sformatf("fp_gnt_c%0d", k), {b_gnt1, b_gnt0}, exp_bg);
      if (k >= 2 && k % 2 == 0) chk($sformatf("fp_done_c%0d", k), {b_done1, b_done0}, 2'b01);
    end
    next_cyc(); #1;
    chk("rr_done_tail", {a_done1, a_done0}, 2'b00);

    // Reset during SERVE of a port-1 store drops it.
    next_cyc(); req1 = 1'b1; we1 = 1'b1; addr1 = 8'd3; wdata1 = 32'h55; #1;
    chk("rm_gnt", {a_gnt1, a_gnt0}, 2'b10);
    next_cyc(); req1 = 1'b0; rst = 1'b0; #1;
    chk("rm_mem_we", a_mem_we, 1'b0);
    chk("rm_mem_we_fp", b_mem_we, 1'b0);
    chk("rm_gnt_none", {a_gnt1, a_gnt0}, 2'b00);
    next_cyc(); rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'd9; addr1 = 8'd10; #1;
    chk("rm_busy", a_busy, 1'b0);
    chk("rm_done", {a_done1, a_done0}, 2'b00);
    chk("rm_mem3", mem_arr_a[3], 32'd3);
    chk("rm_tie_gnt", {a_gnt1, a_gnt0}, 2'b01);
    next_cyc(); req0 = 1'b0; req1 = 1'b0; #1;
    chk("rm_done_none", {a_done1, a_done0}, 2'b00);
    next_cyc(); #1;
    chk("rm_tie_done", {a_done1, a_done0}, 2'b01);
    chk("rm_tie_rdata0", a_rdata0, 32'd9);

    // Back-to-back on port 0: new request granted in the done0 cycle.
    next_cyc(); req0 = 1'b1; we0 = 1'b1; addr0 = 8'd4; wdata0 = 32'hA5A5_A5A5; #1;
    chk("bb_gnt1", {a_gnt1, a_gnt0}, 2'b01);
    next_cyc(); req0 = 1'b0; #1;
    next_cyc(); req0 = 1'b1; we0 = 1'b0; #1;
    chk("bb_done1", {a_done1, a_done0}, 2'b01);
    chk("bb_gnt2", {a_gnt1, a_gnt0}, 2'b01);
    chk("bb_rdata_old", a_rdata0, 32'd4);
    next_cyc(); req0 = 1'b0; #1;
    chk("bb_gap", {a_done1, a_done0}, 2'b00);
    next_cyc(); #1;
    chk("bb_done2", {a_done1, a_done0}, 2'b01);
    chk("bb_rdata_new", a_rdata0, 32'hA5A5_A5A5);

    next_cyc(); next_cyc(); #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
